// File: rtl/nibble_serial_adder.sv
// Nibble-serial adder: adds two 4*NIBBLES-bit operands one 4-bit carry-lookahead
// slice per clock, presenting the result through a valid/ready handshake.
module nibble_serial_adder #(
  parameter int NIBBLES = 4
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   IN_VALID,
  output logic                   IN_READY,
  input  logic [4*NIBBLES-1:0]   A,
  input  logic [4*NIBBLES-1:0]   B,
  input  logic                   CIN,
  output logic                   OUT_VALID,
  input  logic                   OUT_READY,
  output logic [4*NIBBLES-1:0]   SUM,
  output logic                   COUT,
  output logic                   BUSY
);

  localparam int WIDTH = 4 * NIBBLES;
  localparam int CW    = $clog2(NIBBLES + 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // One 4-bit lookahead slice; result is {carry_out, sum[3:0]}.
  function automatic logic [4:0] add_slice(
    input logic [3:0] a,
    input logic [3:0] b,
    input logic       cin
  );
    logic [3:0] p;
    logic [3:0] g;
    logic [3:0] s;
    logic [4:0] c;
    p    = a ^ b;
    g    = a & b;
    c[0] = cin;
    for (int i = 0; i < 4; i++) begin
      c[i+1] = g[i] | (c[i] & p[i]);
      s[i]   = p[i] ^ c[i];
    end
    return {c[4], s};
  endfunction

  state_t             r_state;
  state_t             w_state_nxt;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [WIDTH-1:0]   r_acc;
  logic               r_carry;
  logic [CW-1:0]      r_cnt;
  logic [WIDTH-1:0]   r_sum;
  logic               r_cout;
  logic               r_in_ready;
  logic               r_out_valid;
  logic               r_busy;

  logic [4:0]         w_slice;
  logic               w_last;
  logic [WIDTH-1:0]   w_acc_nxt;

  assign w_slice   = add_slice(r_a[3:0], r_b[3:0], r_carry);
  assign w_last    = (r_cnt == CW'(NIBBLES - 1));
  assign w_acc_nxt = (r_acc >> 3'd4) | (WIDTH'(w_slice[3:0]) << (WIDTH - 4));

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (IN_VALID) begin
          w_state_nxt = ST_RUN;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (w_last) begin
          w_state_nxt = ST_DONE;
        end else begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_DONE: begin
        if (OUT_READY) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_DONE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Handshake flags are registered copies of the next-state decode.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_in_ready  <= (w_state_nxt == ST_IDLE);
      r_out_valid <= (w_state_nxt == ST_DONE);
      r_busy      <= (w_state_nxt != ST_IDLE);
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_a     <= {WIDTH{1'b0}};
      r_b     <= {WIDTH{1'b0}};
      r_acc   <= {WIDTH{1'b0}};
      r_carry <= 1'b0;
      r_cnt   <= {CW{1'b0}};
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (IN_VALID) begin
            r_a     <= A;
            r_b     <= B;
            r_carry <= CIN;
            r_cnt   <= {CW{1'b0}};
          end else begin
            r_carry <= r_carry;
          end
        end
        ST_RUN: begin
          r_a     <= r_a >> 3'd4;
          r_b     <= r_b >> 3'd4;
          r_acc   <= w_acc_nxt;
          r_carry <= w_slice[4];
          r_cnt   <= r_cnt + CW'(1'b1);
        end
        default: begin
          r_cnt <= r_cnt;
        end
      endcase
    end
  end

  // The visible result only changes on the final slice so it survives the next run.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_sum  <= {WIDTH{1'b0}};
      r_cout <= 1'b0;
    end else begin
      if ((r_state == ST_RUN) && w_last) begin
        r_sum  <= w_acc_nxt;
        r_cout <= w_slice[4];
      end else begin
        r_sum  <= r_sum;
        r_cout <= r_cout;
      end
    end
  end

  assign IN_READY  = r_in_ready;
  assign OUT_VALID = r_out_valid;
  assign BUSY      = r_busy;
  assign SUM       = r_sum;
  assign COUT      = r_cout;

endmodule
